// File: rtl/alu_result_stage.sv
// ALU result stage: picks one precomputed unit result by opcode, derives Z/N/C/V flags
// and passes the entry through a registered 2-entry skid buffer with valid/ready on both sides.
module alu_result_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] r_and,
  input  logic [W-1:0] r_or,
  input  logic [W-1:0] r_nor,
  input  logic [W-1:0] r_xor,
  input  logic [W-1:0] r_sum,
  input  logic         c_sum,
  input  logic         v_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_z,
  output logic         out_n,
  output logic         out_c,
  output logic         out_v,
  output logic         out_err,
  output logic [15:0]  xfer_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Entry layout: {err, z, n, c, v, result}
  localparam int PW = W + 5;

  state_t          state_r;
  state_t          state_nx_s;
  logic [PW-1:0]   main_r;
  logic [PW-1:0]   skid_r;
  logic [PW-1:0]   in_entry_s;
  logic [W-1:0]    sel_result_s;
  logic            sel_arith_s;
  logic            sel_err_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [15:0]     xfer_count_r;
  logic            acc_s;
  logic            xfer_s;
  logic            load_main_s;
  logic            load_skid_s;
  logic            skid_to_main_s;

  assign acc_s  = in_valid && in_ready_r;
  assign xfer_s = out_valid_r && out_ready;

  // Result select and flag derivation for the incoming operation
  always_comb begin
    sel_result_s = {W{1'b0}};
    sel_arith_s  = 1'b0;
    sel_err_s    = 1'b0;
    case (op)
      3'd0:       sel_result_s = r_and;
      3'd1:       sel_result_s = r_or;
      3'd2:       sel_result_s = r_nor;
      3'd3:       sel_result_s = r_xor;
      3'd4, 3'd5: begin
        sel_result_s = r_sum;
        sel_arith_s  = 1'b1;
      end
      default:    sel_err_s = 1'b1;
    endcase
    in_entry_s = {sel_err_s, (sel_result_s == {W{1'b0}}), sel_result_s[W-1],
                  sel_arith_s & c_sum, sel_arith_s & v_sum, sel_result_s};
  end

  // Buffer occupancy next-state and entry movement
  always_comb begin
    state_nx_s     = state_r;
    load_main_s    = 1'b0;
    load_skid_s    = 1'b0;
    skid_to_main_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (acc_s) begin
          load_main_s = 1'b1;
          state_nx_s  = ST_ONE;
        end else begin
          state_nx_s  = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (acc_s && xfer_s) begin
          load_main_s = 1'b1;
        end else if (acc_s) begin
          load_skid_s = 1'b1;
          state_nx_s  = ST_FULL;
        end else if (xfer_s) begin
          state_nx_s  = ST_EMPTY;
        end else begin
          state_nx_s  = ST_ONE;
        end
      end
      ST_FULL: begin
        if (xfer_s) begin
          skid_to_main_s = 1'b1;
          state_nx_s     = ST_ONE;
        end else begin
          state_nx_s     = ST_FULL;
        end
      end
      default: state_nx_s = ST_EMPTY;
    endcase
  end

  // State and handshake flags; in_ready comes from a flop so it never sees out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      out_valid_r <= (state_nx_s != ST_EMPTY);
      in_ready_r  <= (state_nx_s != ST_FULL);
    end
  end

  // Payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= {PW{1'b0}};
      skid_r <= {PW{1'b0}};
    end else begin
      if (load_main_s) begin
        main_r <= in_entry_s;
      end else if (skid_to_main_s) begin
        main_r <= skid_r;
      end
      if (load_skid_s) begin
        skid_r <= in_entry_s;
      end
    end
  end

  // Completed output transfer counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_r <= 16'd0;
    end else if (xfer_s) begin
      xfer_count_r <= xfer_count_r + 16'd1;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = main_r[W-1:0];
  assign out_v      = main_r[W];
  assign out_c      = main_r[W+1];
  assign out_n      = main_r[W+2];
  assign out_z      = main_r[W+3];
  assign out_err    = main_r[W+4];
  assign xfer_count = xfer_count_r;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the gate-level ALU function units (AND/OR/NOR/XOR/adder). It selects one precomputed result bus by opcode and derives Z/N/C/V flags. The selected result is held in a 2-entry skid buffer with valid/ready handshakes on both sides, so the datapath can stall without dropping operations. A transfer counter supports debug and verification.

## Interface
- W, default 32: datapath width; legal values are 2 to 64.
- clk  input  1: rising-edge clock.
- rst_n  input  1: reset, asynchronous assert, active-low.
- in_valid  input  1: upstream holds a valid operation.
- in_ready  output  1: stage can accept an operation this cycle.
- op  input  3: result select. 0 AND, 1 OR, 2 NOR, 3 XOR, 4 ADD, 5 SUB, 6–7 illegal.
- r_and, r_or, r_nor, r_xor  input  W: bitwise unit results.
- r_sum  input  W: adder result. For op 5 the upstream has already applied B inversion and carry-in 1.
- c_sum  input  1: adder carry-out.
- v_sum  input  1: adder signed overflow.
- out_valid  output  1: out_* fields are valid.
- out_ready  input  1: downstream accepts this cycle.
- out_result  output  W: selected result.
- out_z, out_n, out_c, out_v  output  1 each: result flags.
- out_err  output  1: the entry came from an illegal opcode.
- xfer_count  output  16: count of completed output transfers.

## Operation
- An input is accepted when in_valid && in_ready. The output transfers when out_valid && out_ready.
- Select and flag rules, evaluated at accept time:
  - The result is the bus chosen by op.
  - Z = (result == 0).
  - N = result[W-1].
  - C = c_sum for op 4/5, else 0.
  - V = v_sum for op 4/5, else 0.
  - For op 6/7: result = 0, Z = 1, N = C = V = 0, err = 1. The entry is still accepted and transferred normally.
- Buffer uses two entries, MAIN (drives out_*) and SKID. States:
  - EMPTY: out_valid = 0, in_ready = 1. An accept loads MAIN and moves to ONE.
  - ONE: out_valid = 1, in_ready = 1.
    - Accept with transfer: MAIN is reloaded and the state stays ONE.
    - Accept without transfer: the new entry loads SKID and the state moves to FULL.
    - Transfer without accept: moves to EMPTY.
  - FULL: out_valid = 1, in_ready = 0.
    - Transfer: SKID moves to MAIN and the state moves to ONE.
    - No transfer: the state holds.
- in_ready is a registered signal and depends only on state, never combinationally on out_ready.
- out_* fields are stable while out_valid && !out_ready.
- xfer_count increments by 1 on each output transfer. It wraps from 0xFFFF to 0x0000.
- Payload registers are not required to clear on leaving a state. Only the state, out_valid, in_ready and xfer_count carry reset-defined values in operation.

## Timing
- Latency: an op accepted at edge k appears on out_* with out_valid = 1 after edge k. It is visible in the cycle after the accept.
- Throughput: one op per cycle while out_ready = 1.
- in_ready falls the cycle after SKID fills and rises the cycle after SKID drains into MAIN.
- Reset takes effect asynchronously on rst_n low, including mid-transfer. The values below hold until the first clk edge with rst_n high:
  - State is EMPTY.
  - out_valid = 0, in_ready = 1.
  - out_result = 0.
  - out_z = out_n = out_c = out_v = out_err = 0.
  - xfer_count = 0.
  - Any entries held in MAIN or SKID are discarded.
- Reset release: the first accept can occur on the first rising edge after rst_n goes high.
- In EMPTY, in_valid with out_ready = 1 does not transfer in the same cycle. There is no combinational bypass.

## Test plan
- Reset, then stream 4 ops with out_ready = 1 (W = 32): op 2 with r_nor = 0x0000_0000, op 1 with r_or = 0x8000_0001, op 4 with r_sum = 0 and c_sum = 1, op 5 with r_sum = 0x7FFF_FFFF and v_sum = 1. Required outputs, one per cycle starting the cycle after the first accept:
  - Op 2: Z = 1.
  - Op 1: N = 1, Z = 0.
  - Op 4: Z = 1, C = 1.
  - Op 5: V = 1, N = 0.
  - xfer_count = 4.
- Backpressure: with out_ready = 0, drive 3 ops with results A, B, C back to back.
  - Required: A and B are accepted, in_ready = 0 from the cycle after B, and C is held.
  - Raise out_ready. Required output order is A, B, C with no loss and no duplication.
- Hold stability: stall with out_ready = 0 for 10 cycles while changing all r_* inputs.
  - Required: out_result and the flags stay constant.
- Illegal op: op = 7 with all r_* = 0xFFFF_FFFF.
  - Required: out_result = 0, Z = 1, err = 1, and it transfers normally.
- Async reset: assert rst_n low between edges while FULL.
  - Required: out_valid = 0 and in_ready = 1 immediately, before the next clk edge.
  - Required: xfer_count = 0, and neither buffered entry ever appears after release.
- Counter wrap: preload by streaming 65,536 transfers with random stall and random ops.
  - Required: xfer_count = 0x0000, and a scoreboard matches every output against a reference model.
